dm_arbiter: RTL and testbench



---
 rtl/dm_arbiter_if.sv | 45 ++++
 rtl/dm_arbiter.sv | 81 ++++++++
 tb/tb_dm_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dm_arbiter_if.sv
// dm_arbiter_if: bundle of the two requester ports and the data-memory port
// Ports (signals):
//   m0_*/m1_* : req, we, addr, wdata (requester -> arbiter); gnt, rvalid, rdata (arbiter -> requester)
//   dm_*      : addr, rd, wr, wdata (arbiter -> memory); rdata (memory -> arbiter)
// Modports: slave = arbiter view, master = requester/memory environment view
interface dm_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;
  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;
  logic [ADDR_W-1:0] dm_addr;
  logic              dm_rd;
  logic              dm_wr;
  logic [DATA_W-1:0] dm_wdata;
  logic [DATA_W-1:0] dm_rdata;
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output dm_addr, dm_rd, dm_wr, dm_wdata,
    input  dm_rdata
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  dm_addr, dm_rd, dm_wr, dm_wdata,
    output dm_rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester round-robin arbiter in front of the single-port data memory
// Ports:
//   clk   : clock, all state on posedge
//   rst_n : asynchronous active-low reset
//   bus   : dm_arbiter_if.slave -- requester 0 (CPU MEM), requester 1 (loader/debug), memory port
// Pipeline: grant in cycle T, memory access in T+1, registered response (rvalid) in T+2.
module dm_arbiter #(
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 32,
  parameter int PRIO_INIT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  dm_arbiter_if.slave  bus
);
  logic              ptr;
  logic              g0;
  logic              g1;
  logic              acc_v;
  logic              acc_we;
  logic              acc_id;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              rv0;
  logic              rv1;
  logic [DATA_W-1:0] rd0;
  logic [DATA_W-1:0] rd1;
  // ptr names the requester that wins a tie; grants are forced low while in reset
  always_comb begin
    g0 = rst_n && bus.m0_req && (!bus.m1_req || !ptr);
    g1 = rst_n && bus.m1_req && (!bus.m0_req || ptr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= 1'(PRIO_INIT);
      acc_v     <= 1'b0;
      acc_we    <= 1'b0;
      acc_id    <= 1'b0;
      acc_addr  <= '0;
      acc_wdata <= '0;
    end else begin
      if (g0 || g1) ptr <= g0;
      acc_v <= g0 || g1;
      if (g0 || g1) begin
        acc_id    <= g1;
        acc_we    <= g1 ? bus.m1_we    : bus.m0_we;
        acc_addr  <= g1 ? bus.m1_addr  : bus.m0_addr;
        acc_wdata <= g1 ? bus.m1_wdata : bus.m0_wdata;
      end
    end
  end
  // memory port is quiet (all zero) whenever the access stage is empty
  always_comb begin
    bus.dm_rd    = acc_v && !acc_we;
    bus.dm_wr    = acc_v && acc_we;
    bus.dm_addr  = acc_v ? acc_addr  : '0;
    bus.dm_wdata = acc_v ? acc_wdata : '0;
  end
  // writes also capture dm_rdata: the memory bypasses wdata, so this acts as the write ack data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv0 <= 1'b0;
      rv1 <= 1'b0;
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      rv0 <= acc_v && !acc_id;
      rv1 <= acc_v && acc_id;
      if (acc_v && !acc_id) rd0 <= bus.dm_rdata;
      if (acc_v && acc_id) rd1 <= bus.dm_rdata;
    end
  end
  always_comb begin
    bus.m0_gnt    = g0;
    bus.m1_gnt    = g1;
    bus.m0_rvalid = rv0;
    bus.m1_rvalid = rv1;
    bus.m0_rdata  = rd0;
    bus.m1_rdata  = rd1;
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed + random check of dm_arbiter against a grant-order memory model
module tb_dm_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;
  typedef struct {
    int             t;
    bit             id;
    bit             we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [DW-1:0]  data;
  } op_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) a ();
  dm_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b ();
  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_INIT(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
  dm_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIO_INIT(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));
  logic [DW-1:0] mem_a [128];
  assign a.dm_rdata = a.dm_wr ? a.dm_wdata : mem_a[a.dm_addr];
  always @(posedge clk) if (a.dm_wr) mem_a[a.dm_addr] <= a.dm_wdata;
  assign b.dm_rdata = b.dm_wr ? b.dm_wdata : 32'h0BAD_F00D;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit ptr_m = 1'b0;
  op_t q[$];
  logic [DW-1:0] ref_mem [128];
  logic [DW-1:0] rd_m [2];
  bit commit_v = 1'b0;
  logic [AW-1:0] commit_a;
  logic [DW-1:0] commit_d;
  bit last_g0 = 1'b0;
  bit last_g1 = 1'b0;
  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic step(input bit r0, input bit w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input bit r1, input bit w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bit eg0, eg1, acc_v, rsp_v;
    op_t acc, rsp, n;
    @(negedge clk);
    if (commit_v) begin
      ref_mem[commit_a] = commit_d;
      commit_v = 1'b0;
    end
    a.m0_req = r0; a.m0_we = w0; a.m0_addr = a0; a.m0_wdata = d0;
    a.m1_req = r1; a.m1_we = w1; a.m1_addr = a1; a.m1_wdata = d1;
    #1;
    eg0 = r0 && (!r1 || ptr_m == 1'b0);
    eg1 = r1 && (!r0 || ptr_m == 1'b1);
    chk("gnt0", a.m0_gnt, eg0);
    chk("gnt1", a.m1_gnt, eg1);
    chk("one_gnt", a.m0_gnt & a.m1_gnt, 0);
    acc = '{default: 0};
    rsp = '{default: 0};
    acc_v = 1'b0;
    rsp_v = 1'b0;
    foreach (q[i]) begin
      if (q[i].t == cyc - 1) begin
        q[i].data = q[i].we ? q[i].wdata : ref_mem[q[i].addr];
        acc = q[i];
        acc_v = 1'b1;
      end
      if (q[i].t == cyc - 2) begin
        rsp = q[i];
        rsp_v = 1'b1;
      end
    end
    chk("dm_rd", a.dm_rd, acc_v && !acc.we);
    chk("dm_wr", a.dm_wr, acc_v && acc.we);
    chk("dm_addr", a.dm_addr, acc_v ? acc.addr : 0);
    chk("dm_wdata", a.dm_wdata, acc_v ? acc.wdata : 0);
    if (acc_v && acc.we) begin
      commit_v = 1'b1;
      commit_a = acc.addr;
      commit_d = acc.wdata;
    end
    if (rsp_v) rd_m[rsp.id] = rsp.data;
    chk("rvalid0", a.m0_rvalid, rsp_v && !rsp.id);
    chk("rvalid1", a.m1_rvalid, rsp_v && rsp.id);
    chk("rdata0", a.m0_rdata, rd_m[0]);
    chk("rdata1", a.m1_rdata, rd_m[1]);
    while (q.size() > 0 && q[0].t < cyc - 1) void'(q.pop_front());
    if (eg0 || eg1) begin
      n.t = cyc; n.id = eg1; n.we = eg1 ? w1 : w0;
      n.addr = eg1 ? a1 : a0; n.wdata = eg1 ? d1 : d0; n.data = '0;
      q.push_back(n);
      ptr_m = eg0;
    end
    last_g0 = eg0;
    last_g1 = eg1;
    cyc++;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic reset_now();
    rst_n = 1'b0;
    a.m0_req = 1'b0;
    a.m1_req = 1'b0;
    #1;
    chk("rst_gnt0", a.m0_gnt, 0);
    chk("rst_gnt1", a.m1_gnt, 0);
    chk("rst_dm_rd", a.dm_rd, 0);
    chk("rst_dm_wr", a.dm_wr, 0);
    chk("rst_dm_addr", a.dm_addr, 0);
    chk("rst_dm_wdata", a.dm_wdata, 0);
    chk("rst_rvalid0", a.m0_rvalid, 0);
    chk("rst_rvalid1", a.m1_rvalid, 0);
    chk("rst_rdata0", a.m0_rdata, 0);
    chk("rst_rdata1", a.m1_rdata, 0);
    chk("rst_b_rvalid1", b.m1_rvalid, 0);
    q.delete();
    ptr_m = 1'b0;
    rd_m[0] = '0;
    rd_m[1] = '0;
    commit_v = 1'b0;
  endtask
  task automatic release_rst();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic [DW-1:0] v3;
    bit p0, p1, w0, w1;
    logic [AW-1:0] a0, a1;
    logic [DW-1:0] d0, d1;
    a.m0_req = 0; a.m0_we = 0; a.m0_addr = '0; a.m0_wdata = '0;
    a.m1_req = 0; a.m1_we = 0; a.m1_addr = '0; a.m1_wdata = '0;
    b.m0_req = 0; b.m0_we = 0; b.m0_addr = '0; b.m0_wdata = '0;
    b.m1_req = 0; b.m1_we = 0; b.m1_addr = '0; b.m1_wdata = '0;
    #2;
    reset_now();
    release_rst();
    for (int i = 0; i < 16; i++) step(1, 1, AW'(i), $urandom, 0, 0, 0, 0);
    idle(2);
    v3 = ref_mem[3];
    step(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
    idle(2);
    chk("wr5_ack", a.m0_rdata, 32'hDEADBEEF);
    step(0, 0, 0, 0, 1, 0, 5, 0);
    idle(2);
    chk("rd5_m1", a.m1_rdata, 32'hDEADBEEF);
    reset_now();
    release_rst();
    for (int i = 0; i < 6; i++) step(1, 0, AW'(i), 0, 1, 0, AW'(i + 8), 0);
    idle(2);
    step(1, 1, 9, 32'h12345678, 0, 0, 0, 0);
    step(1, 0, 9, 0, 0, 0, 0, 0);
    idle(2);
    chk("raw9", a.m0_rdata, 32'h12345678);
    step(1, 1, 3, 32'hAAAA5555, 0, 0, 0, 0);
    idle(1);
    reset_now();
    release_rst();
    step(1, 0, 3, 0, 0, 0, 0, 0);
    idle(2);
    chk("rd3_after_rst", a.m0_rdata, v3);
    p0 = 0; p1 = 0; w0 = 0; w1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    for (int k = 0; k < 400; k++) begin
      if (!(p0 && !last_g0 && $urandom_range(3) != 0)) begin
        p0 = 1'($urandom_range(1)); w0 = 1'($urandom_range(1));
        a0 = AW'($urandom_range(15)); d0 = $urandom;
      end
      if (!(p1 && !last_g1 && $urandom_range(3) != 0)) begin
        p1 = 1'($urandom_range(1)); w1 = 1'($urandom_range(1));
        a1 = AW'($urandom_range(15)); d1 = $urandom;
      end
      step(p0, w0, a0, d0, p1, w1, a1, d1);
    end
    idle(3);
    reset_now();
    release_rst();
    @(negedge clk);
    b.m0_req = 1; b.m1_req = 1;
    #1;
    chk("b_first_gnt1", b.m1_gnt, 1);
    chk("b_first_gnt0", b.m0_gnt, 0);
    @(negedge clk);
    b.m1_req = 0;
    #1;
    chk("b_next_gnt0", b.m0_gnt, 1);
    chk("b_next_gnt1", b.m1_gnt, 0);
    @(negedge clk);
    b.m0_req = 0;
    #1;
    chk("b_rvalid1", b.m1_rvalid, 1);
    chk("b_rdata1", b.m1_rdata, 32'h0BAD_F00D);
    @(negedge clk);
    #1;
    chk("b_rvalid0", b.m0_rvalid, 1);
    chk("b_rvalid1_off", b.m1_rvalid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
